// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions: forward-select encodings and the in-flight producer tag entry.
package fwd_hazard_unit_pkg;

  localparam int RA_W_MAX = 8;
  localparam int SEL_W    = 3;

  localparam logic [SEL_W-1:0] FWD_RF = 3'd0;
  localparam logic [SEL_W-1:0] FWD_E0 = 3'd1;
  localparam logic [SEL_W-1:0] FWD_E1 = 3'd2;
  localparam logic [SEL_W-1:0] FWD_E2 = 3'd3;
  localparam logic [SEL_W-1:0] FWD_E3 = 3'd4;
  localparam logic [SEL_W-1:0] FWD_E4 = 3'd5;
  localparam logic [SEL_W-1:0] FWD_E5 = 3'd6;
  localparam logic [SEL_W-1:0] FWD_E6 = 3'd7;

  // rd is stored zero-extended so one struct serves every register-address width up to RA_W_MAX
  typedef struct packed {
    logic                v;
    logic                we;
    logic [RA_W_MAX-1:0] rd;
    logic                ld;
  } tagEntry_t;

  localparam tagEntry_t BUBBLE = '0;

  function automatic tagEntry_t makeTag(input logic v, input logic we,
                                        input logic [RA_W_MAX-1:0] rd, input logic ld);
    tagEntry_t t;
    t.v  = v;
    t.we = we;
    t.rd = rd;
    t.ld = ld;
    return t;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Per-source operand matcher: finds the youngest in-flight producer of one source register
// and flags a load result that cannot be forwarded yet.
module fwd_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int RA_W   = 3,
  parameter int DEPTH  = 3,
  parameter int LD_LAT = 1
) (
  input  logic                   idValid,
  input  logic                   srcUsed,
  input  logic [RA_W-1:0]        srcAddr,
  input  tagEntry_t [DEPTH-1:0]  tags,
  output logic [SEL_W-1:0]       sel,
  output logic                   loadHit
);

  logic [RA_W_MAX-1:0] srcExt;

  assign srcExt = RA_W_MAX'(srcAddr);

  // Scan oldest to youngest so the youngest match is the last one written
  always_comb begin
    sel     = FWD_RF;
    loadHit = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (idValid && srcUsed && tags[k].v && tags[k].we && (tags[k].rd == srcExt)) begin
        sel     = SEL_W'(k + 1);
        loadHit = tags[k].ld && (k < LD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight producers, selects forward paths
// for the instruction entering EX and requests a stall on an unresolved load-use dependency.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int RA_W   = 3,
  parameter int NSRC   = 2,
  parameter int DEPTH  = 3,
  parameter int LD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic                   id_we,
  input  logic [RA_W-1:0]        id_rd,
  input  logic                   id_is_load,
  input  logic [NSRC*RA_W-1:0]   id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic                   flush,
  input  logic                   freeze,
  output logic                   stall,
  output logic [NSRC*SEL_W-1:0]  fwd_sel,
  output logic [CNT_W-1:0]       hazard_cnt
);

  tagEntry_t [DEPTH-1:0]  tags;
  logic [NSRC*SEL_W-1:0]  matchSel;
  logic [NSRC-1:0]        loadHit;

  for (genvar i = 0; i < NSRC; i++) begin : gSrc
    fwd_match #(
      .RA_W   (RA_W),
      .DEPTH  (DEPTH),
      .LD_LAT (LD_LAT)
    ) uMatch (
      .idValid (id_valid),
      .srcUsed (id_src_used[i]),
      .srcAddr (id_src[i*RA_W +: RA_W]),
      .tags    (tags),
      .sel     (matchSel[i*SEL_W +: SEL_W]),
      .loadHit (loadHit[i])
    );
  end

  assign stall = rst_n && !freeze && !flush && (|loadHit);

  // Freeze holds everything; stall and flush both push a bubble instead of the ID instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags       <= '0;
      fwd_sel    <= '0;
      hazard_cnt <= '0;
    end else if (!freeze) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        tags[k] <= tags[k-1];
      end
      if (flush || stall) begin
        tags[0] <= BUBBLE;
        fwd_sel <= '0;
      end else begin
        tags[0] <= makeTag(id_valid, id_we, RA_W_MAX'(id_rd), id_is_load);
        fwd_sel <= matchSel;
      end
      if (stall && (hazard_cnt != {CNT_W{1'b1}})) begin
        hazard_cnt <= hazard_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit (RA_W=3, NSRC=2, DEPTH=3, LD_LAT=1, CNT_W=2).
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_we = 1'b0;
  logic [2:0]  id_rd = '0;
  logic        id_is_load = 1'b0;
  logic [5:0]  id_src = '0;
  logic [1:0]  id_src_used = '0;
  logic        flush = 1'b0;
  logic        freeze = 1'b0;
  logic        stall;
  logic [5:0]  fwd_sel;
  logic [1:0]  hazard_cnt;

  typedef struct {
    string      name;
    logic       eStall;
    logic [5:0] eSel;
    logic [1:0] eCnt;
  } expRec_t;

  expRec_t scoreQ[$];
  int checks = 0;
  int errors = 0;
  logic [1:0] expCnt;

  fwd_hazard_unit #(
    .RA_W   (3),
    .NSRC   (2),
    .DEPTH  (3),
    .LD_LAT (1),
    .CNT_W  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_we       (id_we),
    .id_rd       (id_rd),
    .id_is_load  (id_is_load),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .flush       (flush),
    .freeze      (freeze),
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .hazard_cnt  (hazard_cnt)
  );

  always #5 clk = ~clk;

  task automatic pushExp(input string nm, input logic eStall, input logic [2:0] eSel0,
                         input logic [2:0] eSel1, input logic [1:0] eCnt);
    expRec_t r;
    r.name   = nm;
    r.eStall = eStall;
    r.eSel   = {eSel1, eSel0};
    r.eCnt   = eCnt;
    scoreQ.push_back(r);
  endtask

  // Expected fwd_sel/hazard_cnt describe state produced by the previous vector; stall is for this one
  task automatic applyStimulus(input string nm, input logic v, input logic we, input logic [2:0] rd,
                               input logic ld, input logic [2:0] s0, input logic [2:0] s1,
                               input logic [1:0] used, input logic fl, input logic fr,
                               input logic eStall, input logic [2:0] eSel0,
                               input logic [2:0] eSel1, input logic [1:0] eCnt);
    @(posedge clk);
    #1;
    id_valid    = v;
    id_we       = we;
    id_rd       = rd;
    id_is_load  = ld;
    id_src      = {s1, s0};
    id_src_used = used;
    flush       = fl;
    freeze      = fr;
    pushExp(nm, eStall, eSel0, eSel1, eCnt);
  endtask

  task automatic checkOutput(input expRec_t r);
    checks++;
    if (stall !== r.eStall) begin
      errors++;
      $display("[TB] FAIL %s.stall: got %0b expected %0b", r.name, stall, r.eStall);
    end
    checks++;
    if (fwd_sel !== r.eSel) begin
      errors++;
      $display("[TB] FAIL %s.fwd_sel: got %0d/%0d expected %0d/%0d", r.name,
               fwd_sel[2:0], fwd_sel[5:3], r.eSel[2:0], r.eSel[5:3]);
    end
    checks++;
    if (hazard_cnt !== r.eCnt) begin
      errors++;
      $display("[TB] FAIL %s.hazard_cnt: got %0d expected %0d", r.name, hazard_cnt, r.eCnt);
    end
  endtask

  initial begin : monitor
    expRec_t r;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (scoreQ.size() > 0) begin
        r = scoreQ.pop_front();
        checkOutput(r);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d checks so far", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #1;
    pushExp("reset", 1'b0, 3'd0, 3'd0, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // name          v   we  rd  ld  s0  s1  used  fl fr  stall sel0 sel1 cnt
    applyStimulus("addR1",      1, 1, 3'd1, 0, 3'd2, 3'd3, 2'b11, 0, 0, 0, 3'd0, 3'd0, 2'd0);
    applyStimulus("addR2R1R3",  1, 1, 3'd2, 0, 3'd1, 3'd3, 2'b11, 0, 0, 0, 3'd0, 3'd0, 2'd0);
    applyStimulus("fwdEx",      0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd1, 3'd0, 2'd0);

    applyStimulus("ldR1",       1, 1, 3'd1, 1, 3'd5, 3'd6, 2'b01, 0, 0, 0, 3'd0, 3'd0, 2'd0);
    applyStimulus("loadUse",    1, 1, 3'd2, 0, 3'd1, 3'd1, 2'b11, 0, 0, 1, 3'd0, 3'd0, 2'd0);
    applyStimulus("afterStall", 1, 1, 3'd2, 0, 3'd1, 3'd1, 2'b11, 0, 0, 0, 3'd0, 3'd0, 2'd1);
    applyStimulus("fwdMem",     0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd2, 3'd2, 2'd1);

    applyStimulus("addR4a",     1, 1, 3'd4, 0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd0, 3'd0, 2'd1);
    applyStimulus("addR5",      1, 1, 3'd5, 0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd0, 3'd0, 2'd1);
    applyStimulus("addR4b",     1, 1, 3'd4, 0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd0, 3'd0, 2'd1);
    applyStimulus("readR4",     1, 1, 3'd6, 0, 3'd4, 3'd7, 2'b11, 0, 0, 0, 3'd0, 3'd0, 2'd1);
    applyStimulus("youngest",   0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd1, 3'd0, 2'd1);

    applyStimulus("ldR3",       1, 1, 3'd3, 1, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd0, 3'd0, 2'd1);
    applyStimulus("unusedSrc",  1, 0, 3'd0, 0, 3'd3, 3'd3, 2'b00, 0, 0, 0, 3'd0, 3'd0, 2'd1);
    applyStimulus("unusedSel",  0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd0, 3'd0, 2'd1);

    applyStimulus("ldR2",       1, 1, 3'd2, 1, 3'd3, 3'd0, 2'b01, 0, 0, 0, 3'd0, 3'd0, 2'd1);
    applyStimulus("freeze1",    1, 1, 3'd7, 0, 3'd2, 3'd0, 2'b01, 0, 1, 0, 3'd3, 3'd0, 2'd1);
    applyStimulus("freeze2",    1, 1, 3'd7, 0, 3'd2, 3'd0, 2'b01, 0, 1, 0, 3'd3, 3'd0, 2'd1);
    applyStimulus("freeze3",    1, 1, 3'd7, 0, 3'd2, 3'd0, 2'b01, 0, 1, 0, 3'd3, 3'd0, 2'd1);
    applyStimulus("thawStall",  1, 1, 3'd7, 0, 3'd2, 3'd0, 2'b01, 0, 0, 1, 3'd3, 3'd0, 2'd1);
    applyStimulus("thawAfter",  1, 1, 3'd7, 0, 3'd2, 3'd0, 2'b01, 0, 0, 0, 3'd0, 3'd0, 2'd2);
    applyStimulus("thawFwd",    0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd2, 3'd0, 2'd2);

    applyStimulus("ldR3b",      1, 1, 3'd3, 1, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd0, 3'd0, 2'd2);
    applyStimulus("flushUse",   1, 1, 3'd3, 0, 3'd3, 3'd3, 2'b11, 1, 0, 0, 3'd0, 3'd0, 2'd2);
    applyStimulus("bubbleE0",   1, 0, 3'd0, 0, 3'd3, 3'd0, 2'b01, 0, 0, 0, 3'd0, 3'd0, 2'd2);
    applyStimulus("flushFwd",   0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd2, 3'd0, 2'd2);

    expCnt = 2'd2;
    for (int j = 0; j < 5; j++) begin
      applyStimulus("satLoad",  1, 1, 3'd1, 1, 3'd0, 3'd0, 2'b00, 0, 0, 0,
                    (j == 0) ? 3'd0 : 3'd2, 3'd0, expCnt);
      applyStimulus("satStall", 1, 0, 3'd0, 0, 3'd1, 3'd0, 2'b01, 0, 0, 1, 3'd0, 3'd0, expCnt);
      expCnt = (expCnt == 2'd3) ? 2'd3 : expCnt + 2'd1;
      applyStimulus("satAfter", 1, 0, 3'd0, 0, 3'd1, 3'd0, 2'b01, 0, 0, 0, 3'd0, 3'd0, expCnt);
    end
    applyStimulus("satFwd",     0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd2, 3'd0, 2'd3);

    applyStimulus("preRstLoad", 1, 1, 3'd1, 1, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd0, 3'd0, 2'd3);
    applyStimulus("preRstUse",  1, 0, 3'd0, 0, 3'd1, 3'd0, 2'b01, 0, 0, 1, 3'd0, 3'd0, 2'd3);
    @(negedge clk);
    #2;
    pushExp("rstMidStall", 1'b0, 3'd0, 3'd0, 2'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pushExp("postReset", 1'b0, 3'd0, 3'd0, 2'd0);
    applyStimulus("emptyPipe",  0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0, 0, 0, 3'd0, 3'd0, 2'd0);

    repeat (3) @(posedge clk);
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations expected 0", scoreQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter RA_W, default 3, register address width.
REQ-002 SHALL have parameter NSRC, default 2, source operands per instruction (Ra, Rb, ...).
REQ-003 SHALL have parameter DEPTH, default 3, number of in-flight producer entries tracked (EX, MEM, WB, ...); range 2..7.
REQ-004 SHALL have parameter LD_LAT, default 1, number of youngest entries in which a load result is not yet forwardable; range 0..DEPTH-1.
REQ-005 SHALL have parameter CNT_W, default 16, hazard counter width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 id_valid  in  1  instruction present in ID.
REQ-009 id_we  in  1  ID instruction writes a register.
REQ-010 id_rd  in  RA_W  ID destination register.
REQ-011 id_is_load  in  1  ID instruction is a load.
REQ-012 id_src  in  NSRC*RA_W  ID source addresses, source i at bits [i*RA_W +: RA_W].
REQ-013 id_src_used  in  NSRC  per-source "operand is read" flag.
REQ-014 flush  in  1  squash the ID instruction (branch taken).
REQ-015 freeze  in  1  whole-pipeline freeze (external memory wait).
REQ-016 stall  out  1  combinational load-use stall request to PC/IF/ID.
REQ-017 fwd_sel  out  NSRC*3  registered forward select per source for the instruction now in EX; 0 = register file, k = entry k-1 (1 = EX/MEM, 2 = MEM/WB, ...).
REQ-018 hazard_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-019 SHALL hold a tag pipeline E[0..DEPTH-1], each {v, we, rd, ld}; E[0] = instruction in EX, E[k] older.
REQ-020 Source i SHALL match E[k] when id_valid, id_src_used[i], E[k].v, E[k].we and E[k].rd == id_src i all hold.
REQ-021 Youngest match (lowest k) SHALL win; older matches ignored.
REQ-022 stall SHALL be 1 when any source's youngest match has E[k].ld = 1 and k < LD_LAT; SHALL be 0 when freeze = 1 or flush = 1.
REQ-023 Priority per cycle: reset > freeze > flush > stall > advance.
REQ-024 Advance: E shifts (E[k+1] <= E[k]); E[0] <= {id_valid, id_we, id_rd, id_is_load}; fwd_sel source i <= 1 + youngest-match index, or 0 if none.
REQ-025 Stall: E shifts; E[0] <= bubble (v = 0); fwd_sel <= 0.
REQ-026 Flush: as stall (bubble into E[0], fwd_sel <= 0).
REQ-027 Freeze: E, fwd_sel and hazard_cnt SHALL hold.
REQ-028 E[DEPTH-1] SHALL be discarded on shift.
REQ-029 hazard_cnt SHALL increment by 1 on each cycle with stall = 1, saturating at all-ones.
REQ-030 Latency: ID-to-fwd_sel one cycle; stall zero cycles (same-cycle combinational).
REQ-031 The same register written by multiple in-flight entries SHALL select the youngest; a source with id_src_used = 0 SHALL never stall or forward.

Reset
REQ-032 rst_n low SHALL asynchronously clear all E[k].v, fwd_sel to 0, and hazard_cnt to 0; stall SHALL read 0 while in reset.
REQ-033 Reset mid-stall SHALL drop the stall; the first cycle after release SHALL treat the pipeline as empty.

Structure
REQ-034 Forward-select encodings (FWD_RF = 0, FWD_E0 = 1, ...) and the tag-entry struct SHALL live in the shared pipeline package.
REQ-035 Per-source match and priority logic SHALL be one sub-module, fwd_match, instantiated NSRC times.

Verification
REQ-036 Back-to-back ADD r1 then ADD r2,r1,r3 -> no stall; consumer fwd_sel for Ra = 1 in EX.
REQ-037 LD r1 then ADD r2,r1,r1 (LD_LAT = 1) -> stall = 1 for exactly 1 cycle; hazard_cnt += 1; next cycle both selects = 2.
REQ-038 Writes to r4 in E[0] and E[2], consumer reads r4 -> select = 1 (youngest), not 3.
REQ-039 Load-use hazard with freeze = 1 for 3 cycles -> stall = 0 and all state held; after release, stall asserts for 1 cycle.
REQ-040 flush with a pending load-use -> stall = 0, bubble enters E[0], next fwd_sel = 0.
REQ-041 CNT_W = 2, 5 stall cycles -> hazard_cnt sticks at 3; rst_n pulsed mid-stall -> all outputs 0 immediately.
